// File: rtl/tplatch_bank.sv
// tplatch_bank: CHANNELS independent WIDTH-bit latches emulated synchronously
// on MasterClock. Each channel has its own enable, and there is a global freeze.
// Each channel also provides a sticky Valid flag and a one-cycle Closed pulse.
// TRANSPARENT selects between pass-through while open (1) and a purely
// registered output (0).
// Optional feature: define TPLATCH_BANK_SNAPSHOT_EN to add the Snap/SnapQ
// snapshot register, which captures the combinational Q on request.
module tplatch_bank #(
    parameter int              WIDTH       = 8,
    parameter int              CHANNELS    = 4,
    parameter int              TRANSPARENT = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                        MasterClock,
    input  logic                        Reset,
    input  logic [WIDTH*CHANNELS-1:0]   D,
    input  logic [CHANNELS-1:0]         EB,
    input  logic                        Freeze,
    output logic [WIDTH*CHANNELS-1:0]   Q,
    output logic [CHANNELS-1:0]         Valid,
`ifdef TPLATCH_BANK_SNAPSHOT_EN
    input  logic                        Snap,
    output logic [WIDTH*CHANNELS-1:0]   SnapQ,
`endif
    output logic [CHANNELS-1:0]         Closed
);

    localparam int TW = WIDTH * CHANNELS;

    logic [CHANNELS-1:0] ebe;
    logic [TW-1:0]       held_q, held_d;
    logic [CHANNELS-1:0] valid_q, valid_d;
    logic [CHANNELS-1:0] en_prev_q, en_prev_d;
    logic [CHANNELS-1:0] closed_q, closed_d;

    // Freeze masks every enable, so it behaves exactly like a close.
    assign ebe = EB & {CHANNELS{~Freeze}};

    // Next-state: capture open channels, remember the enable, and detect the falling enable.
    always_comb begin
        held_d    = held_q;
        valid_d   = valid_q | ebe;
        en_prev_d = ebe;
        closed_d  = en_prev_q & ~ebe;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ebe[c]) begin
                held_d[c*WIDTH +: WIDTH] = D[c*WIDTH +: WIDTH];
            end
        end
    end

    // State registers; reset discards any capture in progress, including a pending close.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            held_q    <= {CHANNELS{RESET_VAL}};
            valid_q   <= '0;
            en_prev_q <= '0;
            closed_q  <= '0;
        end else begin
            held_q    <= held_d;
            valid_q   <= valid_d;
            en_prev_q <= en_prev_d;
            closed_q  <= closed_d;
        end
    end

    // Output mux: pass D through on open channels in transparent mode; reset overrides combinationally.
    always_comb begin
        Q = held_q;
        if (TRANSPARENT != 0) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ebe[c]) begin
                    Q[c*WIDTH +: WIDTH] = D[c*WIDTH +: WIDTH];
                end
            end
        end
        if (Reset) begin
            Q = {CHANNELS{RESET_VAL}};
        end
    end

    assign Valid  = valid_q;
    assign Closed = closed_q;

`ifdef TPLATCH_BANK_SNAPSHOT_EN
    logic [TW-1:0] snap_q, snap_d;

    // Snapshot next value: grab the visible Q, ignoring Freeze.
    always_comb begin
        snap_d = snap_q;
        if (Snap) begin
            snap_d = Q;
        end
    end

    // Snapshot register.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            snap_q <= {CHANNELS{RESET_VAL}};
        end else begin
            snap_q <= snap_d;
        end
    end

    assign SnapQ = snap_q;
`endif

endmodule

// File: tb/tb_tplatch_bank.sv
// Table-driven bench for tplatch_bank. It compares a transparent instance and
// a registered instance side by side on the same stimulus.
module tb_tplatch_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d;
    logic [3:0]  eb;
    logic        frz;
    logic        snap;
    logic [31:0] q_t, q_r;
    logic [3:0]  v_t, v_r, c_t, c_r;
`ifdef TPLATCH_BANK_SNAPSHOT_EN
    logic [31:0] sq_t, sq_r;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tplatch_bank #(.WIDTH(8), .CHANNELS(4), .TRANSPARENT(1), .RESET_VAL(8'h00)) dut_t (
        .MasterClock(clk), .Reset(rst), .D(d), .EB(eb), .Freeze(frz),
        .Q(q_t), .Valid(v_t),
`ifdef TPLATCH_BANK_SNAPSHOT_EN
        .Snap(snap), .SnapQ(sq_t),
`endif
        .Closed(c_t)
    );

    tplatch_bank #(.WIDTH(8), .CHANNELS(4), .TRANSPARENT(0), .RESET_VAL(8'h00)) dut_r (
        .MasterClock(clk), .Reset(rst), .D(d), .EB(eb), .Freeze(frz),
        .Q(q_r), .Valid(v_r),
`ifdef TPLATCH_BANK_SNAPSHOT_EN
        .Snap(snap), .SnapQ(sq_r),
`endif
        .Closed(c_r)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  eb;
        logic        frz;
        logic [31:0] d;
        logic [31:0] q_t;
        logic [31:0] q_r;
        logic [3:0]  v;
        logic [3:0]  c;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] e, input logic f,
                         input logic [31:0] dv, input logic s);
        rst  = r;
        eb   = e;
        frz  = f;
        d    = dv;
        snap = s;
    endtask

    // Advance from the mid-cycle sample point to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst eb    frz d              q_t            q_r            v     c
        tbl[0]  = '{1'b1, 4'hF, 1'b0, 32'hA5A5A5A5, 32'h00000000, 32'h00000000, 4'h0, 4'h0};
        tbl[1]  = '{1'b1, 4'hF, 1'b0, 32'hA5A5A5A5, 32'h00000000, 32'h00000000, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 4'hF, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 4'hF, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'hF, 4'h0};
        tbl[4]  = '{1'b0, 4'h0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'hF, 4'h0};
        tbl[5]  = '{1'b0, 4'h0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'hF, 4'hF};
        tbl[6]  = '{1'b0, 4'h1, 1'b0, 32'hA5A5A511, 32'hA5A5A511, 32'hA5A5A5A5, 4'hF, 4'h0};
        tbl[7]  = '{1'b0, 4'h1, 1'b0, 32'hA5A5A522, 32'hA5A5A522, 32'hA5A5A511, 4'hF, 4'h0};
        tbl[8]  = '{1'b0, 4'h1, 1'b0, 32'hA5A5A533, 32'hA5A5A533, 32'hA5A5A522, 4'hF, 4'h0};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 32'hA5A5A5FF, 32'hA5A5A533, 32'hA5A5A533, 4'hF, 4'h0};
        tbl[10] = '{1'b0, 4'h0, 1'b0, 32'hA5A5A5FF, 32'hA5A5A533, 32'hA5A5A533, 4'hF, 4'h1};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 32'hA5A5A5FF, 32'hA5A5A533, 32'hA5A5A533, 4'hF, 4'h0};
        tbl[12] = '{1'b0, 4'hF, 1'b0, 32'h44444444, 32'h44444444, 32'hA5A5A533, 4'hF, 4'h0};
        tbl[13] = '{1'b0, 4'hF, 1'b1, 32'h77777777, 32'h44444444, 32'h44444444, 4'hF, 4'h0};
        tbl[14] = '{1'b0, 4'hF, 1'b1, 32'h77777777, 32'h44444444, 32'h44444444, 4'hF, 4'hF};
        tbl[15] = '{1'b0, 4'hF, 1'b0, 32'h77777777, 32'h77777777, 32'h44444444, 4'hF, 4'h0};
        tbl[16] = '{1'b0, 4'hF, 1'b0, 32'h77777777, 32'h77777777, 32'h77777777, 4'hF, 4'h0};
        tbl[17] = '{1'b0, 4'h4, 1'b0, 32'h77777777, 32'h77777777, 32'h77777777, 4'hF, 4'h0};
        tbl[18] = '{1'b1, 4'h4, 1'b0, 32'h12121212, 32'h00000000, 32'h00000000, 4'hF, 4'hB};
        tbl[19] = '{1'b0, 4'h0, 1'b0, 32'h12121212, 32'h00000000, 32'h00000000, 4'h0, 4'h0};
        tbl[20] = '{1'b0, 4'h0, 1'b0, 32'h12121212, 32'h00000000, 32'h00000000, 4'h0, 4'h0};
        tbl[21] = '{1'b0, 4'h4, 1'b0, 32'h00560000, 32'h00560000, 32'h00000000, 4'h0, 4'h0};
        tbl[22] = '{1'b0, 4'h0, 1'b0, 32'h00000000, 32'h00560000, 32'h00560000, 4'h4, 4'h0};
        tbl[23] = '{1'b0, 4'h0, 1'b0, 32'h00000000, 32'h00560000, 32'h00560000, 4'h4, 4'h4};
        tbl[24] = '{1'b0, 4'h0, 1'b0, 32'h00000000, 32'h00560000, 32'h00560000, 4'h4, 4'h0};

        // Put every flop into a known state before the first checked row.
        drive(1'b1, 4'h0, 1'b0, 32'h0, 1'b0);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].eb, tbl[i].frz, tbl[i].d, 1'b0);
            @(negedge clk);
            chk($sformatf("row%0d q_transp", i), q_t, tbl[i].q_t);
            chk($sformatf("row%0d q_reg", i), q_r, tbl[i].q_r);
            chk($sformatf("row%0d valid_t", i), {28'd0, v_t}, {28'd0, tbl[i].v});
            chk($sformatf("row%0d valid_r", i), {28'd0, v_r}, {28'd0, tbl[i].v});
            chk($sformatf("row%0d closed_t", i), {28'd0, c_t}, {28'd0, tbl[i].c});
            chk($sformatf("row%0d closed_r", i), {28'd0, c_r}, {28'd0, tbl[i].c});
            next_cycle();
        end

        // Freeze while the latch is already closed is not a close event.
        drive(1'b0, 4'h0, 1'b1, 32'h00000000, 1'b0);
        next_cycle();
        drive(1'b0, 4'h8, 1'b0, 32'h99000000, 1'b0);
        @(negedge clk);
        chk("frz_idle closed", {28'd0, c_t}, 32'h0);
        chk("ch3 open q_t", q_t, 32'h99560000);
        next_cycle();
        // Freeze one open channel, then release it with EB still high.
        drive(1'b0, 4'h8, 1'b1, 32'hAB000000, 1'b0);
        @(negedge clk);
        chk("frz ch3 q_t", q_t, 32'h99560000);
        chk("frz ch3 valid", {28'd0, v_t}, 32'hC);
        chk("frz ch3 closed_pre", {28'd0, c_t}, 32'h0);
        next_cycle();
        drive(1'b0, 4'h8, 1'b0, 32'hAB000000, 1'b0);
        @(negedge clk);
        chk("frz ch3 closed", {28'd0, c_t}, 32'h8);
        chk("unfrz q_t", q_t, 32'hAB560000);
        chk("unfrz q_r", q_r, 32'h99560000);
        next_cycle();
        @(negedge clk);
        chk("unfrz closed_none", {28'd0, c_r}, 32'h0);
        chk("unfrz q_r_cap", q_r, 32'hAB560000);
        next_cycle();

`ifdef TPLATCH_BANK_SNAPSHOT_EN
        // Snapshot while channel 1 shows 8'h5A, then change D[1] with EB[1] still high.
        drive(1'b0, 4'h2, 1'b0, 32'h00005A00, 1'b1);
        @(negedge clk);
        chk("snap pre q_t", q_t, 32'hAB565A00);
        next_cycle();
        drive(1'b0, 4'h2, 1'b0, 32'h0000C300, 1'b0);
        @(negedge clk);
        chk("snap hold t", sq_t, 32'hAB565A00);
        chk("snap hold r", sq_r, 32'hAB560000);
        chk("snap closed ch3", {28'd0, c_t}, 32'h8);
        next_cycle();
        // Snap during Freeze is still honoured.
        drive(1'b0, 4'h0, 1'b1, 32'h00000000, 1'b1);
        @(negedge clk);
        chk("snap keep t", sq_t, 32'hAB565A00);
        next_cycle();
        drive(1'b0, 4'h0, 1'b0, 32'h00000000, 1'b0);
        @(negedge clk);
        chk("snap frz t", sq_t, 32'hAB56C300);
        chk("snap frz r", sq_r, 32'hAB56C300);
        next_cycle();
        drive(1'b1, 4'h0, 1'b0, 32'h00000000, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("snap reset", sq_t, 32'h00000000);
        next_cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
